// File: rtl/dmem_bridge.sv
// dmem_bridge: memory stage to SRAM-like data bus bridge; define DMEM_BRIDGE_PERF_CNT_EN to build the stall_cycles counter
module dmem_bridge #(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   mem_req,
    input  logic                   mem_wr,
    input  logic [1:0]             mem_size,
    input  logic [3:0]             mem_wstrb,
    input  logic [31:0]            mem_address,
    input  logic [31:0]            write_mem_data,
    input  logic                   flush,
    input  logic                   wb_allowin,
    output logic [31:0]            read_mem_data,
    output logic                   mem_stall,
    output logic                   data_req,
    output logic                   data_wr,
    output logic [1:0]             data_size,
    output logic [3:0]             data_wstrb,
    output logic [31:0]            data_addr,
    output logic [31:0]            data_wdata,
    input  logic                   data_addr_ok,
    input  logic                   data_data_ok,
    input  logic [31:0]            data_rdata,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, WAIT = 3'd2, DONE = 3'd3, CANCEL = 3'd4;
    logic [2:0] state, state_nxt;
    logic       cancel, cancel_nxt, kill;
    assign kill = flush | cancel;
    assign data_wr    = mem_wr;
    assign data_size  = mem_size;
    assign data_wstrb = mem_wstrb;
    assign data_addr  = mem_address;
    assign data_wdata = write_mem_data;
    // resetn gates the combinational outputs so they read 0 while reset is held
    assign data_req  = resetn & (state == IDLE ? mem_req & ~flush : state == REQ);
    assign mem_stall = resetn & (state == DONE ? 1'b0 : state == CANCEL ? mem_req : mem_req & ~flush);
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = data_req ? (data_addr_ok ? WAIT : REQ) : IDLE;
            REQ:     state_nxt = data_addr_ok ? (kill ? CANCEL : WAIT) : REQ;
            WAIT:    state_nxt = data_data_ok ? (kill ? IDLE : DONE) : (kill ? CANCEL : WAIT);
            DONE:    state_nxt = (wb_allowin | flush) ? IDLE : DONE;
            CANCEL:  state_nxt = data_data_ok ? IDLE : CANCEL;
            default: state_nxt = IDLE;
        endcase
        cancel_nxt = (state_nxt == IDLE) ? 1'b0 : kill;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            cancel        <= 1'b0;
            read_mem_data <= '0;
        end else begin
            state  <= state_nxt;
            cancel <= cancel_nxt;
            if (state == WAIT && data_data_ok && !kill && !mem_wr)
                read_mem_data <= data_rdata;
        end
    end
`ifdef DMEM_BRIDGE_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            stall_cycles <= '0;
        else if (mem_stall && !(&stall_cycles))
            stall_cycles <= stall_cycles + 1'b1;
    end
`else
    assign stall_cycles = '0;
`endif
endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 32, giving the stall-counter width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port mem_req, input, 1, access request from the memory-access stage.
REQ-005 SHALL have port mem_wr, input, 1, 1 = store, 0 = load.
REQ-006 SHALL have port mem_size, input, 2, 00 = byte, 01 = half, 10 = word.
REQ-007 SHALL have port mem_wstrb, input, 4, byte write strobes.
REQ-008 SHALL have port mem_address, input, 32, byte address.
REQ-009 SHALL have port write_mem_data, input, 32, store data, already lane-aligned.
REQ-010 SHALL have port flush, input, 1, exception/eret pipeline flush.
REQ-011 SHALL have port wb_allowin, input, 1, downstream stage accepts this instruction.
REQ-012 SHALL have port read_mem_data, output, 32, registered load data returned to the memory-access stage.
REQ-013 SHALL have port mem_stall, output, 1, holds the memory-access stage.
REQ-014 SHALL have ports data_req/data_wr/data_size/data_wstrb/data_addr/data_wdata, outputs, 1/1/2/4/32/32, SRAM-like bus request.
REQ-015 SHALL have ports data_addr_ok/data_data_ok/data_rdata, inputs, 1/1/32, SRAM-like bus responses.
REQ-016 SHALL have port stall_cycles, output, STALL_CNT_W, stall performance counter.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT, DONE, CANCEL.
REQ-018 IDLE: data_req = mem_req & ~flush; if data_addr_ok, go to WAIT, else go to REQ when data_req.
REQ-019 REQ: data_req = 1 held regardless of flush; on data_addr_ok go to WAIT (CANCEL if flush seen since issue).
REQ-020 data_wr/size/wstrb/addr/wdata SHALL pass through from mem_* combinationally; upstream holds them stable while mem_stall = 1.
REQ-021 WAIT: on data_data_ok, capture data_rdata into read_mem_data (loads only; stores leave it unchanged), go to DONE; flush while in WAIT goes to CANCEL.
REQ-022 DONE: mem_stall = 0; go to IDLE when wb_allowin or flush.
REQ-023 CANCEL: wait for data_data_ok, discard data, go to IDLE; data_req = 0.
REQ-024 mem_stall = mem_req & ~flush in IDLE, REQ, and WAIT, 0 in DONE, and mem_req in CANCEL.
REQ-025 A pending flush SHALL be latched in a sticky cancel bit cleared on entry to IDLE.
REQ-026 data_data_ok in IDLE, REQ or DONE SHALL be ignored; the bus never returns data_ok in the addr_ok cycle.
REQ-027 Minimum load latency SHALL be 2 cycles of mem_stall (addr_ok in cycle 0, data_ok in cycle 1, data valid with stall low in cycle 2).
REQ-028 At most one transaction SHALL be outstanding.

Reset
REQ-029 On resetn low: state = IDLE, read_mem_data = 0, cancel bit = 0, stall_cycles = 0, data_req = 0, mem_stall = 0.
REQ-030 Reset mid-transaction SHALL abandon it without waiting for data_ok.

Configuration
REQ-031 With DMEM_BRIDGE_PERF_CNT_EN defined, stall_cycles SHALL increment each cycle mem_stall = 1, saturating at all-ones.
REQ-032 Without DMEM_BRIDGE_PERF_CNT_EN, stall_cycles SHALL be constant 0 and no counter SHALL be built.

Verification
REQ-033 Load word at 0x100 with addr_ok in cycle 0 and data_ok=1/rdata=0xDEADBEEF in cycle 1 -> stall is 1 for 2 cycles, then read_mem_data = 0xDEADBEEF with stall = 0.
REQ-034 Store with addr_ok delayed by 3 cycles -> data_req high with stable data_addr/wstrb for 4 cycles; stall released one cycle after data_ok.
REQ-035 Flush in WAIT, then a new load request -> old rdata discarded; new data_req only after old data_ok; read_mem_data = new data.
REQ-036 Flush in IDLE with mem_req = 1 -> data_req = 0 and mem_stall = 0 that cycle.
REQ-037 DONE with wb_allowin = 0 for 3 cycles -> read_mem_data stable and no new data_req.
REQ-038 DMEM_BRIDGE_PERF_CNT_EN, STALL_CNT_W = 2, 5 stall cycles -> stall_cycles = 3 (saturated); without the macro -> 0.
